// File: rtl/key_event_decoder.sv
// Key event decoder: turns a debounced key level into press, release, long-press
// and auto-repeat pulses. Every output is registered.
//
// state   | meaning
// IDLE    | key released, waiting for a press
// PRESSED | key held, counting toward the long-press threshold
// LONG    | long press reached, counting auto-repeat intervals
module key_event_decoder #(
   parameter int CNT_W      = 16,
   parameter int LONG_CNT   = 1000,
   parameter int REPEAT_CNT = 200
) (
   input  logic clk,
   input  logic reset_n,
   input  logic key_in,
   input  logic repeat_en,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_pulse,
   output logic repeat_pulse,
   output logic key_held
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESSED = 2'd1,
      LONG    = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CNT - 1);
   localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CNT - 1);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= IDLE;
         r_cnt         <= '0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         long_pulse    <= 1'b0;
         repeat_pulse  <= 1'b0;
         key_held      <= 1'b0;
      end else begin
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         long_pulse    <= 1'b0;
         repeat_pulse  <= 1'b0;
         case (r_state)
            IDLE: begin
               r_cnt <= '0;
               if (key_in) begin
                  r_state     <= PRESSED;
                  press_pulse <= 1'b1;
                  key_held    <= 1'b1;
               end else begin
                  key_held    <= 1'b0;
               end
            end
            PRESSED: begin
               // release is checked first so it wins over a coincident threshold
               if (!key_in) begin
                  r_state       <= IDLE;
                  r_cnt         <= '0;
                  release_pulse <= 1'b1;
                  key_held      <= 1'b0;
               end else if (r_cnt == LONG_LAST) begin
                  r_state    <= LONG;
                  r_cnt      <= '0;
                  long_pulse <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            LONG: begin
               if (!key_in) begin
                  r_state       <= IDLE;
                  r_cnt         <= '0;
                  release_pulse <= 1'b1;
                  key_held      <= 1'b0;
               end else if (r_cnt == REPEAT_LAST) begin
                  r_cnt        <= '0;
                  repeat_pulse <= repeat_en;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state  <= IDLE;
               r_cnt    <= '0;
               key_held <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder with LONG_CNT=8, REPEAT_CNT=4.
// Edge 1 is the first rising clock edge after reset is released.
module tb_key_event_decoder;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic key_in = 1'b0;
   logic repeat_en = 1'b1;
   logic press_pulse, release_pulse, long_pulse, repeat_pulse, key_held;

   int checks = 0;
   int errors = 0;

   // captured {key_held, repeat, long, release, press} after each edge
   logic [4:0] cap [0:63];

   key_event_decoder #(.CNT_W(16), .LONG_CNT(8), .REPEAT_CNT(4)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .key_in       (key_in),
      .repeat_en    (repeat_en),
      .press_pulse  (press_pulse),
      .release_pulse(release_pulse),
      .long_pulse   (long_pulse),
      .repeat_pulse (repeat_pulse),
      .key_held     (key_held)
   );

   always #5 clk = ~clk;

   function automatic logic [4:0] outs();
      return {key_held, repeat_pulse, long_pulse, release_pulse, press_pulse};
   endfunction

   function automatic logic [63:0] mk(input int lo, input int hi);
      logic [63:0] v;
      v = '0;
      for (int i = lo; i <= hi; i++) v[i] = 1'b1;
      return v;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      key_in  = 1'b0;
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   // key_in = pat[e] is presented before edge e; outputs sampled 1ns after edge e
   task automatic run_seq(input logic [63:0] pat, input int n, input logic rep);
      repeat_en = rep;
      for (int e = 1; e <= n; e++) begin
         if (e > 1) @(negedge clk);
         key_in = pat[e];
         @(posedge clk);
         #1;
         cap[e] = outs();
      end
      @(negedge clk);
      key_in = 1'b0;
   endtask

   task automatic test_reset();
      logic [4:0] exp;
      exp = 5'b0;
      reset_n = 1'b0;
      key_in  = 1'b1;
      #3;
      checks++;
      if (outs() !== exp) begin
         errors++;
         $display("FAIL reset_before_clock: got %b expected %b", outs(), exp);
      end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if (outs() !== exp) begin
            errors++;
            $display("FAIL reset_held_key cycle %0d: got %b expected %b", i, outs(), exp);
         end
      end
      key_in = 1'b0;
   endtask

   task automatic test_short_press();
      logic [4:0] exp;
      do_reset();
      run_seq(mk(10, 13), 18, 1'b1);
      for (int e = 1; e <= 18; e++) begin
         exp = {(e >= 10 && e <= 13), 1'b0, 1'b0, (e == 14), (e == 10)};
         checks++;
         if (cap[e] !== exp) begin
            errors++;
            $display("FAIL short_press edge %0d: got %b expected %b", e, cap[e], exp);
         end
      end
   endtask

   task automatic test_long_repeat();
      logic [4:0] exp;
      do_reset();
      run_seq(mk(10, 29), 34, 1'b1);
      for (int e = 1; e <= 34; e++) begin
         exp = {(e >= 10 && e <= 29), (e == 22 || e == 26), (e == 18), (e == 30), (e == 10)};
         checks++;
         if (cap[e] !== exp) begin
            errors++;
            $display("FAIL long_repeat edge %0d: got %b expected %b", e, cap[e], exp);
         end
      end
   endtask

   task automatic test_threshold_release();
      logic [4:0] exp;
      do_reset();
      run_seq(mk(10, 17), 22, 1'b1);
      for (int e = 1; e <= 22; e++) begin
         exp = {(e >= 10 && e <= 17), 1'b0, 1'b0, (e == 18), (e == 10)};
         checks++;
         if (cap[e] !== exp) begin
            errors++;
            $display("FAIL threshold_release edge %0d: got %b expected %b", e, cap[e], exp);
         end
      end
   endtask

   task automatic test_repeat_gate();
      logic [4:0] exp;
      do_reset();
      run_seq(mk(10, 29), 34, 1'b0);
      for (int e = 1; e <= 34; e++) begin
         exp = {(e >= 10 && e <= 29), 1'b0, (e == 18), (e == 30), (e == 10)};
         checks++;
         if (cap[e] !== exp) begin
            errors++;
            $display("FAIL repeat_gate edge %0d: got %b expected %b", e, cap[e], exp);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [4:0] exp;
      do_reset();
      run_seq(mk(10, 10) | mk(12, 12), 16, 1'b1);
      for (int e = 1; e <= 16; e++) begin
         exp = {(e == 10 || e == 12), 1'b0, 1'b0, (e == 11 || e == 13), (e == 10 || e == 12)};
         checks++;
         if (cap[e] !== exp) begin
            errors++;
            $display("FAIL back_to_back edge %0d: got %b expected %b", e, cap[e], exp);
         end
      end
   endtask

   task automatic test_reset_mid_press();
      logic [4:0] exp;
      do_reset();
      run_seq(mk(10, 40), 14, 1'b1);
      // run_seq leaves key low; put it back high before the next edge
      key_in = 1'b1;
      checks++;
      if (cap[14] !== 5'b10000) begin
         errors++;
         $display("FAIL mid_press_held: got %b expected %b", cap[14], 5'b10000);
      end
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if (outs() !== 5'b0) begin
         errors++;
         $display("FAIL mid_press_async_clear: got %b expected %b", outs(), 5'b0);
      end
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if (outs() !== 5'b0) begin
            errors++;
            $display("FAIL mid_press_in_reset cycle %0d: got %b expected %b", i, outs(), 5'b0);
         end
      end
      @(negedge clk);
      reset_n = 1'b1;
      for (int e = 1; e <= 3; e++) begin
         @(posedge clk);
         #1;
         exp = {1'b1, 1'b0, 1'b0, 1'b0, (e == 1)};
         checks++;
         if (outs() !== exp) begin
            errors++;
            $display("FAIL mid_press_after_reset edge %0d: got %b expected %b", e, outs(), exp);
         end
      end
      @(negedge clk);
      key_in = 1'b0;
   endtask

   initial begin
      test_reset();
      test_short_press();
      test_long_repeat();
      test_threshold_release();
      test_repeat_gate();
      test_back_to_back();
      test_reset_mid_press();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/key_event_decoder.md
KEY_EVENT_DECODER -- requirements
Module: key_event_decoder

Interface
REQ-001 SHALL have parameter CNT_W, default 16, the hold-counter width in bits.
REQ-002 SHALL have parameter LONG_CNT, default 1000, the number of held cycles from the press to the long-press event (legal range 2..2^CNT_W-1).
REQ-003 SHALL have parameter REPEAT_CNT, default 200, the number of cycles between auto-repeat events (legal range 2..2^CNT_W-1).
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit, the reset: asynchronous, active-low.
REQ-006 SHALL have port key_in, input, 1 bit, a debounced key level already synchronous to clk, 1 = pressed.
REQ-007 SHALL have port repeat_en, input, 1 bit, enabling auto-repeat events while the key is in long-press.
REQ-008 SHALL have port press_pulse, output, 1 bit, a one-cycle pulse when a press is detected.
REQ-009 SHALL have port release_pulse, output, 1 bit, a one-cycle pulse when a release is detected.
REQ-010 SHALL have port long_pulse, output, 1 bit, a one-cycle pulse when the long-press threshold is reached.
REQ-011 SHALL have port repeat_pulse, output, 1 bit, a one-cycle pulse on each auto-repeat interval.
REQ-012 SHALL have port key_held, output, 1 bit, which is 1 while the FSM is in PRESSED or LONG.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, PRESSED, LONG; all outputs SHALL be registered.
REQ-014 SHALL, in IDLE with key_in=1 at edge k, move to PRESSED, clear cnt to 0, and assert press_pulse for the cycle after edge k.
REQ-015 SHALL, in PRESSED with key_in=1, increment cnt each edge; at the edge where cnt==LONG_CNT-1 (edge k+LONG_CNT), move to LONG, clear cnt, and pulse long_pulse.
REQ-016 SHALL, in LONG with key_in=1, increment cnt each edge; at the edge where cnt==REPEAT_CNT-1, clear cnt and pulse repeat_pulse only if repeat_en=1 at that edge.
REQ-017 SHALL, in LONG with repeat_en=0, keep counting and wrapping cnt but suppress repeat_pulse.
REQ-018 SHALL, in PRESSED or LONG with key_in=0 at any edge, move to IDLE, clear cnt, and pulse release_pulse.
REQ-019 SHALL give release priority when release coincides with the long or repeat threshold edge: only release_pulse asserts.
REQ-020 SHALL never assert more than one pulse output in the same cycle.
REQ-021 SHALL allow a release followed by a press on the very next edge (IDLE exits immediately) to produce release_pulse then press_pulse in consecutive cycles.
REQ-022 SHALL assert no pulses while in IDLE with key_in=0.
REQ-023 SHALL never overflow cnt: it is bounded by max(LONG_CNT, REPEAT_CNT)-1.
REQ-024 SHALL assert each pulse output for exactly one cycle, deasserting on the following edge unless a new event occurs.

Reset
REQ-025 SHALL, while reset_n=0, immediately force state=IDLE, cnt=0, and all outputs to 0, independent of clk.
REQ-026 SHALL produce no release_pulse when reset is asserted mid-press.
REQ-027 SHALL, if key_in=1 at the first edge after reset_n deasserts, generate press_pulse (a held key is treated as a new press).

Verification (LONG_CNT=8, REPEAT_CNT=4, repeat_en=1)
REQ-028 SHALL cover a short press: key_in high for edges 10..13, low from edge 14 -> press_pulse after edge 10, release_pulse after edge 14, no long_pulse.
REQ-029 SHALL cover a long press with repeat: key_in high from edge 10 to edge 29 -> press after 10, long after 18, repeat after 22 and 26, release after 30.
REQ-030 SHALL cover release on the threshold edge: key_in high for edges 10..17, low at edge 18 -> release_pulse after 18, long_pulse never asserts.
REQ-031 SHALL cover the repeat gate: as REQ-029 but repeat_en=0 -> long_pulse after 18, zero repeat_pulse, release after 30.
REQ-032 SHALL cover reset mid-press: reset_n low at edge 15 during a press, key_in stays high -> outputs 0 during reset, press_pulse on the first edge after reset_n rises.
REQ-033 SHALL cover back-to-back events: key_in 1,0,1 on edges 10,11,12 -> press, release, press pulses in three consecutive cycles.
